// File: rtl/bsg_downstream_link_if.sv
// rtl/bsg_downstream_link_if.sv - link-side and core-side signal bundle for bsg_downstream_link
interface bsg_downstream_link_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Transmitter-facing side
  logic             io_valid_in;
  logic             io_data_in_ch0;
  logic             io_data_in_ch1;
  logic             io_token_out;

  // Core-facing side
  logic [7:0]       core_data_out;
  logic             core_valid_out;
  logic             core_yumi_in;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow_o;

  // Environment: transmitter pins plus core consumer
  modport master (
    output io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    input  io_token_out, core_data_out, core_valid_out, fifo_count, overflow_o
  );

  // The receive link itself
  modport slave (
    input  io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    output io_token_out, core_data_out, core_valid_out, fifo_count, overflow_o
  );
endinterface

// File: rtl/bsg_downstream_link.sv
// rtl/bsg_downstream_link.sv - 2-bit beat deserializer, credit-window FIFO and token return
module bsg_downstream_link #(
  parameter int FIFO_DEPTH  = 8,   // power of two, >= transmitter credit window
  parameter int TOKEN_BATCH = 4    // >= 2; words consumed per returned token
) (
  input  logic                 clk,
  input  logic                 rst,
  bsg_downstream_link_if.slave link
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TB_W  = $clog2(TOKEN_BATCH);

  logic [1:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       asm_q, asm_d;
  logic [7:0]       word_full;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TB_W-1:0]  consumed_q, consumed_d;
  logic             token_q, token_d;
  logic             overflow_q, overflow_d;
  logic             word_done, fifo_full, fifo_empty, pop, push;

  // Beat3 bits bypass the assembly register so the word is pushed on the same edge
  assign word_full  = {link.io_data_in_ch1, asm_q[6], link.io_data_in_ch0, asm_q[4:0]};
  assign word_done  = link.io_valid_in && (beat_cnt_q == 2'd3);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && link.core_yumi_in;
  // At full, a same-cycle pop frees the slot being written
  assign push       = word_done && (!fifo_full || pop);

  // Deserializer: drop the current beat's two bits into their word positions
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    asm_d      = asm_q;
    if (link.io_valid_in) begin
      beat_cnt_d = beat_cnt_q + 2'd1;
      case (beat_cnt_q)
        2'd0: begin asm_d[0] = link.io_data_in_ch0; asm_d[2] = link.io_data_in_ch1; end
        2'd1: begin asm_d[1] = link.io_data_in_ch0; asm_d[3] = link.io_data_in_ch1; end
        2'd2: begin asm_d[4] = link.io_data_in_ch0; asm_d[6] = link.io_data_in_ch1; end
        default: begin asm_d[5] = link.io_data_in_ch0; asm_d[7] = link.io_data_in_ch1; end
      endcase
    end
  end

  // FIFO pointers, occupancy, credit batching and sticky overflow
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    consumed_d = consumed_q;
    token_d    = 1'b0;
    overflow_d = overflow_q | (word_done & ~push);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (pop) begin
      if (consumed_q == TB_W'(TOKEN_BATCH - 1)) begin
        consumed_d = '0;
        token_d    = 1'b1;
      end else begin
        consumed_d = consumed_q + TB_W'(1);
      end
    end
  end

  // State registers; reset wins over any concurrent beat, push or pop
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      consumed_q <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      consumed_q <= consumed_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_full;
  end

  assign link.core_valid_out = !fifo_empty;
  assign link.core_data_out  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign link.fifo_count     = count_q;
  assign link.io_token_out   = token_q;
  assign link.overflow_o     = overflow_q;
endmodule

// File: tb/tb_bsg_downstream_link.sv
// tb/tb_bsg_downstream_link.sv - directed and randomized self-checking bench for bsg_downstream_link
module tb_bsg_downstream_link;
  logic clk = 1'b0;
  logic rst;

  bsg_downstream_link_if #(.FIFO_DEPTH(8)) lnk();

  bsg_downstream_link #(.FIFO_DEPTH(8), .TOKEN_BATCH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (lnk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word queue, beat collector, popped-word total
  byte unsigned mq[$];
  int           mb;
  logic [7:0]   mword;
  bit           movf;
  int           mpops;
  bit           mtok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare every output
  task automatic step(input bit r, input bit v, input bit c0, input bit c1, input bit y);
    bit         popn;
    bit         fullpre;
    bit         done;
    int         idx;
    logic [7:0] w;
    rst                = r;
    lnk.io_valid_in    = v;
    lnk.io_data_in_ch0 = c0;
    lnk.io_data_in_ch1 = c1;
    lnk.core_yumi_in   = y;
    @(posedge clk);
    done = 1'b0;
    w    = 8'h00;
    if (r) begin
      mq.delete();
      mb = 0; mword = 8'h00; movf = 1'b0; mpops = 0; mtok = 1'b0;
    end else begin
      popn    = (mq.size() > 0) && y;
      fullpre = (mq.size() == 8);
      mtok    = 1'b0;
      if (v) begin
        idx = (mb / 2) * 4 + (mb % 2);
        mword[idx]     = c0;
        mword[idx + 2] = c1;
        mb++;
        if (mb == 4) begin done = 1'b1; w = mword; mb = 0; end
      end
      if (popn) begin
        void'(mq.pop_front());
        mpops++;
        if (mpops % 4 == 0) mtok = 1'b1;
      end
      if (done) begin
        if (!fullpre || popn) mq.push_back(w);
        else movf = 1'b1;
      end
    end
    #1;
    chk("valid",    lnk.core_valid_out, 32'(mq.size() > 0));
    chk("data",     lnk.core_data_out,  (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    chk("count",    lnk.fifo_count,     32'(mq.size()));
    chk("overflow", lnk.overflow_o,     32'(movf));
    chk("token",    lnk.io_token_out,   32'(mtok));
  endtask

  task automatic send_word(input logic [7:0] d, input bit y_last, input int gap1);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (k / 2) * 4 + (k % 2);
      step(1'b0, 1'b1, d[idx], d[idx + 2], (k == 3) ? y_last : 1'b0);
      if (k == 1) repeat (gap1) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pop_one();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    do_reset();
    do_reset();
    chk("rst_valid", lnk.core_valid_out, 0);
    chk("rst_data",  lnk.core_data_out,  0);
    chk("rst_count", lnk.fifo_count,     0);
    chk("rst_ovf",   lnk.overflow_o,     0);
    chk("rst_token", lnk.io_token_out,   0);

    // Single word, back-to-back beats
    send_word(8'hA5, 1'b0, 0);
    chk("a5_valid", lnk.core_valid_out, 1);
    chk("a5_data",  lnk.core_data_out,  8'hA5);
    chk("a5_count", lnk.fifo_count,     1);
    chk("a5_token", lnk.io_token_out,   0);
    pop_one();

    // Same word with a 3-cycle gap between beat1 and beat2
    send_word(8'hA5, 1'b0, 3);
    chk("gap_data",  lnk.core_data_out, 8'hA5);
    chk("gap_count", lnk.fifo_count,    1);
    pop_one();

    // Fill to 8, overflow on the 9th, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) send_word(8'(i), 1'b0, 0);
    chk("full_count", lnk.fifo_count,    8);
    chk("full_head",  lnk.core_data_out, 0);
    send_word(8'hFF, 1'b0, 0);
    chk("ovf_set",   lnk.overflow_o, 1);
    chk("ovf_count", lnk.fifo_count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", lnk.core_data_out, i);
      pop_one();
    end
    chk("drain_empty", lnk.core_valid_out, 0);
    chk("ovf_sticky",  lnk.overflow_o,     1);

    // Full with a pop coinciding with the 9th word's beat3
    do_reset();
    chk("ovf_cleared", lnk.overflow_o, 0);
    for (int i = 0; i < 8; i++) send_word(8'(8'h10 + i), 1'b0, 0);
    send_word(8'h99, 1'b1, 0);
    chk("fullpop_ovf",   lnk.overflow_o, 0);
    chk("fullpop_count", lnk.fifo_count, 8);
    for (int i = 0; i < 7; i++) pop_one();
    chk("fullpop_last", lnk.core_data_out, 8'h99);
    pop_one();

    // Token return: 4 consecutive pops give exactly one pulse
    do_reset();
    for (int i = 0; i < 4; i++) send_word(8'(8'h40 + i), 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      pop_one();
      chk("tok_early", lnk.io_token_out, 0);
    end
    pop_one();
    chk("tok_pulse", lnk.io_token_out, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("tok_once", lnk.io_token_out, 0);
    for (int i = 0; i < 4; i++) send_word(8'(8'h50 + i), 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      pop_one();
      chk("tok_three", lnk.io_token_out, 0);
    end
    pop_one();
    chk("tok_fourth", lnk.io_token_out, 1);

    // Reset mid-word discards the partial beats
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrst_valid", lnk.core_valid_out, 0);
    chk("midrst_data",  lnk.core_data_out,  0);
    send_word(8'h3C, 1'b0, 0);
    chk("midrst_word",  lnk.core_data_out, 8'h3C);
    chk("midrst_count", lnk.fifo_count,    1);

    // Randomized traffic against the model, with slow and fast consumer phases
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int  yprob;
      bit  r;
      yprob = ((c / 300) % 2 == 0) ? 8 : 1;
      r     = ($urandom_range(0, 599) == 0);
      step(r, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < yprob);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
